// File: rtl/binary_centroid_pkg.sv
// Shared definitions for the binary_centroid block: FSM state encoding,
// default geometry/width parameters and the quotient saturation helper.
package centroid_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIV_H  = 2'd1,
        DIV_V  = 2'd2,
        UPDATE = 2'd3
    } state_e;

    localparam int H_ACT_DEF      = 320;
    localparam int V_ACT_DEF      = 240;
    localparam int MIN_PIXELS_DEF = 16;
    localparam int CNT_W_DEF      = 17;
    localparam int SUM_W_DEF      = 25;

    // Clamp a quotient to the largest legal coordinate; the caller slices
    // the result down to the port width.
    function automatic logic [31:0] sat_limit(input logic [31:0] value,
                                              input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/binary_centroid_serial_div.sv
// serial_div: unsigned restoring divider, one quotient bit per cycle.
// A start pulse loads the operands; done pulses for one cycle SUM_W+1
// cycles after the start cycle, and quotient then holds until the next start.
module serial_div #(
    parameter int SUM_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [SUM_W-1:0] divisor,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    localparam int CW = $clog2(SUM_W + 1);

    logic [SUM_W-1:0] rem_q, rem_d;
    logic [SUM_W-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [SUM_W:0]   shifted;
    logic             ge;
    logic [SUM_W-1:0] diff;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[SUM_W-1]};
        ge      = (shifted >= {1'b0, divisor});
        // Remainder after a successful subtract is below divisor, so the
        // modulo-2^SUM_W difference is exact.
        diff    = shifted[SUM_W-1:0] - divisor;

        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            cnt_d = CW'(SUM_W);
        end else if (cnt_q != '0) begin
            rem_d  = ge ? diff : shifted[SUM_W-1:0];
            quo_d  = {quo_q[SUM_W-2:0], ge};
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/binary_centroid.sv
// binary_centroid: per-frame blob centroid of a binary mask for the overlay
// renderer. Accumulates hit coordinates, snapshots them at end of frame and
// divides with one time-shared serial divider while the next frame accumulates.
// Optional feature macro CENTROID_SMOOTH_EN: average each new valid centroid
// with the previous one (temporal IIR) instead of loading it directly.
module binary_centroid
    import centroid_pkg::*;
#(
    parameter int H_ACT      = H_ACT_DEF,
    parameter int V_ACT      = V_ACT_DEF,
    parameter int MIN_PIXELS = MIN_PIXELS_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int SUM_W      = SUM_W_DEF
) (
    input  logic        PClk,
    input  logic        Rst_n,
    input  logic        Binary_in,
    input  logic [11:0] VtcHCnt,
    input  logic [10:0] VtcVCnt,
    output logic [11:0] center_h,
    output logic [10:0] center_v,
    output logic        center_valid,
    output logic        busy
);

    localparam logic [11:0]      H_LIM   = 12'(H_ACT);
    localparam logic [11:0]      H_LAST  = 12'(H_ACT - 1);
    localparam logic [10:0]      V_LIM   = 11'(V_ACT);
    localparam logic [10:0]      V_LAST  = 11'(V_ACT - 1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    state_e           state_q, state_d;
    logic             first_q, first_d;
    logic [SUM_W-1:0] sum_h_q, sum_h_d, sum_v_q, sum_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] snap_h_q, snap_h_d, snap_v_q, snap_v_d;
    logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic [11:0]      quo_h_q, quo_h_d;
    logic [11:0]      center_h_q, center_h_d;
    logic [10:0]      center_v_q, center_v_d;
    logic             valid_q, valid_d;

    logic             active, hit, eof, lost;
    logic [SUM_W-1:0] sum_h_inc, sum_v_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic             div_start, div_done;
    logic [SUM_W-1:0] div_dividend, div_quotient;
    logic [11:0]      sat_h;
    logic [10:0]      sat_v;

    serial_div #(.SUM_W(SUM_W)) u_div (
        .clk      (PClk),
        .rst_n    (Rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (SUM_W'(snap_cnt_q)),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Accumulate hits, snapshot at end of frame and restart the sums there.
    always_comb begin
        active    = (VtcHCnt < H_LIM) && (VtcVCnt < V_LIM);
        hit       = active && Binary_in;
        eof       = (VtcHCnt == H_LAST) && (VtcVCnt == V_LAST);
        sum_h_inc = hit ? sum_h_q + SUM_W'(VtcHCnt) : sum_h_q;
        sum_v_inc = hit ? sum_v_q + SUM_W'(VtcVCnt) : sum_v_q;
        cnt_inc   = (hit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

        sum_h_d    = eof ? '0 : sum_h_inc;
        sum_v_d    = eof ? '0 : sum_v_inc;
        cnt_d      = eof ? '0 : cnt_inc;
        // A frame ending while a divide is in flight is dropped.
        first_d    = (state_q == ACCUM) && eof;
        snap_h_d   = first_d ? sum_h_inc : snap_h_q;
        snap_v_d   = first_d ? sum_v_inc : snap_v_q;
        snap_cnt_d = first_d ? cnt_inc   : snap_cnt_q;
    end

    // Sequencer: divide H then V on the shared divider, then update outputs.
    always_comb begin
        state_d      = state_q;
        quo_h_d      = quo_h_q;
        center_h_d   = center_h_q;
        center_v_d   = center_v_q;
        valid_d      = valid_q;
        div_start    = 1'b0;
        div_dividend = snap_h_q;
        lost         = (snap_cnt_q < MIN_CNT);
        sat_h        = 12'(sat_limit(32'(div_quotient), 32'(H_ACT - 1)));
        sat_v        = 11'(sat_limit(32'(div_quotient), 32'(V_ACT - 1)));

        case (state_q)
            ACCUM: begin
                if (eof) state_d = DIV_H;
            end
            DIV_H: begin
                if (first_q) begin
                    if (lost) state_d = UPDATE;
                    else      div_start = 1'b1;
                end else if (div_done) begin
                    // Restart on the done edge so the V divide follows back-to-back.
                    quo_h_d      = sat_h;
                    div_start    = 1'b1;
                    div_dividend = snap_v_q;
                    state_d      = DIV_V;
                end
            end
            DIV_V: begin
                if (div_done) state_d = UPDATE;
            end
            UPDATE: begin
                state_d = ACCUM;
                if (lost) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
`ifdef CENTROID_SMOOTH_EN
                    center_h_d = valid_q ?
                        12'(({1'b0, center_h_q} + {1'b0, quo_h_q} + 13'd1) >> 1) : quo_h_q;
                    center_v_d = valid_q ?
                        11'(({1'b0, center_v_q} + {1'b0, sat_v} + 12'd1) >> 1) : sat_v;
`else
                    center_h_d = quo_h_q;
                    center_v_d = sat_v;
`endif
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State, accumulator, snapshot and output registers.
    always_ff @(posedge PClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ACCUM;
            first_q    <= 1'b0;
            sum_h_q    <= '0;
            sum_v_q    <= '0;
            cnt_q      <= '0;
            snap_h_q   <= '0;
            snap_v_q   <= '0;
            snap_cnt_q <= '0;
            quo_h_q    <= '0;
            center_h_q <= 12'(H_ACT / 2);
            center_v_q <= 11'(V_ACT / 2);
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            sum_h_q    <= sum_h_d;
            sum_v_q    <= sum_v_d;
            cnt_q      <= cnt_d;
            snap_h_q   <= snap_h_d;
            snap_v_q   <= snap_v_d;
            snap_cnt_q <= snap_cnt_d;
            quo_h_q    <= quo_h_d;
            center_h_q <= center_h_d;
            center_v_q <= center_v_d;
            valid_q    <= valid_d;
        end
    end

    assign center_h     = center_h_q;
    assign center_v     = center_v_q;
    assign center_valid = valid_q;
    assign busy         = (state_q != ACCUM);

endmodule
